// File: rtl/fpmul_arb_pkg.sv
// rtl/fpmul_arb_pkg.sv - shared types and constants for the FPmul requester arbiter
package fpmul_arb_pkg;

  localparam int NUM_REQ_MAX = 8;
  localparam int DATA_W_DEF  = 32;
  localparam int STATS_W     = 16;

  typedef logic [$clog2(NUM_REQ_MAX)-1:0] req_idx_t;

  // Ownership tag carried alongside each product through the multiplier latency
  typedef struct packed {
    logic     valid;
    req_idx_t idx;
  } tag_t;

  // Saturating increment for the statistics counters
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant with a registered rotating pointer
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [IW-1:0] ptr;

  // Pick the first requesting slot at or after the pointer, wrapping around
  always_comb begin
    int idx;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = IW'(idx);
      end
    end
  end

  // Move the pointer just past the winner so it gets lowest priority next time
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/fpmul_arbiter.sv
// rtl/fpmul_arbiter.sv - shares one stall-free pipelined FPmul among NUM_REQ requesters; FPMUL_ARB_STATS_EN adds grant/stall counters
module fpmul_arbiter
  import fpmul_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MUL_LATENCY = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [NUM_REQ*DATA_W-1:0] rsp_data,
  output logic [DATA_W-1:0]         mul_a,
  output logic [DATA_W-1:0]         mul_b,
  input  logic [DATA_W-1:0]         mul_z
`ifdef FPMUL_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_W-1:0] grant_cnt,
  output logic [STATS_W-1:0]         stall_cnt
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] busy;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant_oh;
  logic [NUM_REQ-1:0] wb_hit;
  logic [NUM_REQ-1:0] rsp_fire;
  logic [IW-1:0]      grant_idx;
  logic               grant_valid;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;
  tag_t               tag_pipe [MUL_LATENCY];

  // One outstanding op per requester keeps the multiplier free of backpressure
  assign eligible  = req_valid & ~busy & {NUM_REQ{rst_n}};
  assign rsp_fire  = rsp_valid & rsp_ready;
  assign req_ready = grant_oh;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (eligible),
    .grant       (grant_oh),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Operand mux driven by the one-hot grant
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        sel_a = req_a[i*DATA_W +: DATA_W];
        sel_b = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  // Decode the tag leaving the last stage into a per-requester writeback strobe
  always_comb begin
    wb_hit = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wb_hit[i] = tag_pipe[MUL_LATENCY-1].valid &&
                  (tag_pipe[MUL_LATENCY-1].idx == req_idx_t'(i));
    end
  end

  // Busy is set by acceptance and released by the response handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~rsp_fire) | grant_oh;
    end
  end

  // Issue operands and push the owner tag; the tag pipeline never stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_a <= '0;
      mul_b <= '0;
      for (int s = 0; s < MUL_LATENCY; s++) begin
        tag_pipe[s] <= '0;
      end
    end else begin
      if (grant_valid) begin
        mul_a <= sel_a;
        mul_b <= sel_b;
      end
      tag_pipe[0] <= '{valid: grant_valid, idx: req_idx_t'(grant_idx)};
      for (int s = 1; s < MUL_LATENCY; s++) begin
        tag_pipe[s] <= tag_pipe[s-1];
      end
    end
  end

  // Capture the product into the owner's response slot and hold it until consumed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (wb_hit[i]) begin
          rsp_valid[i]                <= 1'b1;
          rsp_data[i*DATA_W +: DATA_W] <= mul_z;
        end else if (rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  // A writeback onto a still-occupied response slot would lose a result
  wb_no_overwrite: assert property (@(posedge clk) disable iff (!rst_n)
    (wb_hit & rsp_valid) == '0);

`ifdef FPMUL_ARB_STATS_EN
  // Saturating per-requester accept counts and a count of contended idle cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_oh[i]) begin
          grant_cnt[i*STATS_W +: STATS_W] <= sat_inc(grant_cnt[i*STATS_W +: STATS_W]);
        end
      end
      if ((|req_valid) && !grant_valid) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
    end
  end
`endif

endmodule
